mem_stage_lsu: RTL
==================

// Module: mem_stage_lsu
// PURPOSE
//  MIPS MEM-stage load/store unit between the EX/MEM pipe register and the byte-lane data RAM.
//  Generates RAM byte enables and replicated store data, and checks alignment and range.
//  Extracts and sign/zero-extends load data, then registers the writeback result as the MEM/WB stage.
//  Valid/ready handshake both sides; address exceptions held until flushed.
// PARAMETERS
//  RAM_WORDS  65536  words in data RAM; byte addr >= RAM_WORDS*4 -> range exception
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   asynchronous, active-low reset
//  flush          in   1   discard input, clear output reg, leave EXC state
//  in_valid       in   1   EX/MEM entry present
//  in_ready       out  1   entry accepted when in_valid & in_ready at posedge
//  in_op          in   4   mem op (package encoding)
//  in_addr        in   32  effective byte address
//  in_wdata       in   32  store data (rt)
//  in_alu         in   32  ALU result, forwarded when op is MEM_NONE
//  in_wb_en       in   1   instruction writes a register
//  in_wreg        in   5   destination register
//  ram_read_en    out  1   RAM read_en
//  ram_write_en   out  1   RAM write_en
//  ram_write_sel  out  4   RAM byte lanes; bit i = bits [8i+7:8i]
//  ram_addr       out  32  = in_addr
//  ram_data_in    out  32  lane-replicated store data
//  ram_data_out   in   32  RAM combinational read data
//  out_valid      out  1   MEM/WB entry present
//  out_ready      in   1   WB consumes entry
//  out_wb_en      out  1   register write enable
//  out_wreg       out  5   destination register
//  out_wdata      out  32  writeback data
//  exc_valid      out  1   address exception pending
//  exc_code       out  2   1=AdEL (load), 2=AdES (store); 0 when none
//  exc_badvaddr   out  32  faulting address
// BEHAVIOUR
//  Reset (rst=0, async): state RUN; out_valid, out_wb_en, exc_valid=0; out_wreg, out_wdata,
//    exc_code, exc_badvaddr=0; ram_read_en, ram_write_en forced 0 while rst=0.
//  in_ready = (state==RUN) & (~out_valid | out_ready) & ~flush.
//  accept = in_valid & in_ready. All RAM controls are combinational and qualified by accept:
//    at most one RAM write per accepted store; none when stalled, flushed or faulting.
//  Little-endian lanes, o = in_addr[1:0]:
//    SB: sel=1<<o, data={4{wdata[7:0]}}; SH: sel=o[1]?4'b1100:4'b0011, data={2{wdata[15:0]}};
//    SW: sel=4'b1111, data=wdata. Loads: ram_read_en=accept, sel=0.
//  Fault: LH/LHU/SH with o[0]=1; LW/SW with o!=0; any load/store with addr >= RAM_WORDS*4.
//    Fault on accept: no RAM access; capture code/badvaddr; exc_valid=1; state -> EXC.
//    Faulting instruction produces no out_valid.
//  Load extract (same cycle as accept, latency 1 to out_*): LB/LBU byte o, LH/LHU half o[1],
//    LW word; LB/LH sign-extend, LBU/LHU zero-extend. Stores: out_wb_en=0.
//    MEM_NONE: out_wdata=in_alu; out_wb_en=in_wb_en. Reserved op codes behave as MEM_NONE.
//  Output reg: on accept (no fault) out_valid=1 and fields load. Else out_valid clears when out_ready.
//  Throughput 1/cycle; back-to-back store then load to same word returns new data.
//  FSM: RUN -(accept & fault)-> EXC; EXC -(flush)-> RUN. In EXC in_ready=0; exc_* stable.
//  flush: wins over all same-cycle events; clears out_valid and exc_valid; state RUN.
//    A store with in_valid in the flush cycle is not written.
//  Reset mid-stall: pending output and exception lost; nothing replayed.
// STRUCTURE
//  Package mips_mem_pkg: op enum MEM_NONE=0,LB=1,LBU=2,LH=3,LHU=4,LW=5,SB=6,SH=7,SW=8;
//    EXC_NONE/ADEL/ADES codes; state enum RUN/EXC.
//  Sub-module load_align: combinational (op, offset, word) -> extended 32-bit result.
// TESTING
//  SB addr=0x103, wdata=0xAB -> sel=4'b1000, ram_data_in=0xABABABAB, single write; then LBU 0x103 -> 0x000000AB.
//  LB 0x103 holding 0x80 -> out_wdata=0xFFFFFF80.
//  LH 0x102 of word 0x8001_1234 -> 0xFFFF8001.
//  LW addr=0x0006 -> exc_valid=1, code=AdEL, badvaddr=0x6, no read, in_ready=0 until flush.
//  SW 0x40000 (RAM_WORDS=65536) -> AdES, ram_write_en never 1.
//  out_ready=0 for 3 cycles during SW, LW stream -> in_ready=0, exactly one write per store, order kept.
//  Flush with SW presented -> no write, out_valid=0 next cycle.
//  rst low mid-stall -> all outputs 0 immediately, RAM strobes 0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types for the MEM-stage load/store unit
//   mem_op_e  : memory operation carried from EX/MEM (unused codes 9-15 act as MEM_NONE)
//   EXC_*     : address exception codes reported on exc_code
//   state_e   : RUN accepts instructions, EXC holds a pending address exception
package mips_mem_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LB       = 4'd1,
        LBU      = 4'd2,
        LH       = 4'd3,
        LHU      = 4'd4,
        LW       = 4'd5,
        SB       = 4'd6,
        SH       = 4'd7,
        SW       = 4'd8
    } mem_op_e;

    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_ADEL = 2'd1;
    localparam logic [1:0] EXC_ADES = 2'd2;

    typedef enum logic {
        RUN = 1'b0,
        EXC = 1'b1
    } state_e;

    function automatic logic op_is_load(logic [3:0] op);
        return op inside {LB, LBU, LH, LHU, LW};
    endfunction

    function automatic logic op_is_store(logic [3:0] op);
        return op inside {SB, SH, SW};
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half/word of a RAM word and extends it
//   op   in  4   memory op
//   off  in  2   byte offset within the word
//   word in  32  RAM read data
//   res  out 32  sign/zero-extended load result (word for LW and non-load ops)
module load_align
    import mips_mem_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] res
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = word[8*off +: 8];
    assign h = off[1] ? word[31:16] : word[15:0];

    always_comb
        res = (op == LB)  ? {{24{b[7]}}, b}  :
              (op == LBU) ? {24'b0, b}        :
              (op == LH)  ? {{16{h[15]}}, h} :
              (op == LHU) ? {16'b0, h}        : word;
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MIPS MEM-stage load/store unit with MEM/WB output register
//   clk, rst(async, active-low), flush
//   in_valid/in_ready, in_op, in_addr, in_wdata, in_alu, in_wb_en, in_wreg : EX/MEM side
//   ram_read_en, ram_write_en, ram_write_sel, ram_addr, ram_data_in, ram_data_out : byte-lane RAM
//   out_valid/out_ready, out_wb_en, out_wreg, out_wdata : MEM/WB side
//   exc_valid, exc_code, exc_badvaddr : pending address exception, held until flush
module mem_stage_lsu
    import mips_mem_pkg::*;
#(
    parameter int RAM_WORDS = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [31:0] in_alu,
    input  logic        in_wb_en,
    input  logic [4:0]  in_wreg,
    output logic        ram_read_en,
    output logic        ram_write_en,
    output logic [3:0]  ram_write_sel,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_data_in,
    input  logic [31:0] ram_data_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_wb_en,
    output logic [4:0]  out_wreg,
    output logic [31:0] out_wdata,
    output logic        exc_valid,
    output logic [1:0]  exc_code,
    output logic [31:0] exc_badvaddr
);
    // 33 bits so a RAM spanning the full 4 GiB still compares correctly
    localparam logic [32:0] ADDR_LIMIT = 33'(RAM_WORDS) * 33'd4;

    state_e      state;
    logic [1:0]  o;
    logic        is_load, is_store, misaligned, fault, accept, do_read, do_write;
    logic [3:0]  st_sel;
    logic [31:0] ld_res;

    assign o          = in_addr[1:0];
    assign is_load    = op_is_load(in_op);
    assign is_store   = op_is_store(in_op);
    assign misaligned = ((in_op inside {LH, LHU, SH}) & o[0]) |
                        ((in_op inside {LW, SW}) & (o != 2'b00));
    assign fault      = (is_load | is_store) & (misaligned | ({1'b0, in_addr} >= ADDR_LIMIT));

    assign in_ready = (state == RUN) & (~out_valid | out_ready) & ~flush;
    assign accept   = in_valid & in_ready;

    // rst gates the strobes so an asserted reset silences the RAM immediately
    assign do_read  = rst & accept & is_load & ~fault;
    assign do_write = rst & accept & is_store & ~fault;

    always_comb
        st_sel = (in_op == SB) ? 4'b0001 << o :
                 (in_op == SH) ? (o[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    assign ram_read_en   = do_read;
    assign ram_write_en  = do_write;
    assign ram_write_sel = do_write ? st_sel : 4'b0000;
    assign ram_addr      = in_addr;
    assign ram_data_in   = (in_op == SB) ? {4{in_wdata[7:0]}}  :
                           (in_op == SH) ? {2{in_wdata[15:0]}} : in_wdata;

    load_align u_align (
        .op   (in_op),
        .off  (o),
        .word (ram_data_out),
        .res  (ld_res)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            out_valid    <= 1'b0;
            out_wb_en    <= 1'b0;
            out_wreg     <= '0;
            out_wdata    <= '0;
            exc_valid    <= 1'b0;
            exc_code     <= EXC_NONE;
            exc_badvaddr <= '0;
        end else if (flush) begin
            state     <= RUN;
            out_valid <= 1'b0;
            exc_valid <= 1'b0;
            exc_code  <= EXC_NONE;
        end else if (accept & fault) begin
            // accept implies any held entry is being consumed this cycle
            state        <= EXC;
            out_valid    <= 1'b0;
            exc_valid    <= 1'b1;
            exc_code     <= is_load ? EXC_ADEL : EXC_ADES;
            exc_badvaddr <= in_addr;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_wb_en <= in_wb_en & ~is_store;
            out_wreg  <= in_wreg;
            out_wdata <= is_load ? ld_res : in_alu;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
